// File: rtl/hb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hb_pkg
// Brief    : Shared halfband widths, coefficients, rounding/saturation and
//            interpolator FSM encoding.
// Revision : 1.0 - initial release
// ============================================================================
package hb_pkg;

    localparam int HB_DW = 18;
    localparam int HB_CW = 25;
    localparam int HB_AW = 48;

    // 11-tap halfband prototype, Q8.17; centre tap (0.5) handled as a pure delay
    localparam logic signed [HB_CW-1:0] HB_C0 = 25'sh0000413;
    localparam logic signed [HB_CW-1:0] HB_C2 = 25'sh1FFE42B;
    localparam logic signed [HB_CW-1:0] HB_C4 = 25'sh00097C7;

    localparam logic signed [HB_DW-1:0] SAT_MAX = 18'sh1FFFF;
    localparam logic signed [HB_DW-1:0] SAT_MIN = 18'sh20000;

    localparam logic signed [HB_AW-1:0] RND_HALF  = 48'sd32768;
    localparam int                      RND_SHIFT = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MAC0  = 3'd1,
        ST_MAC1  = 3'd2,
        ST_MAC2  = 3'd3,
        ST_RND   = 3'd4,
        ST_OUT_E = 3'd5,
        ST_OUT_O = 3'd6
    } hb_state_t;

    function automatic logic signed [HB_DW-1:0] hb_sat(input logic signed [HB_AW-1:0] v);
        logic signed [HB_AW-1:0] lim_hi;
        logic signed [HB_AW-1:0] lim_lo;
        lim_hi = HB_AW'(SAT_MAX);
        lim_lo = HB_AW'(SAT_MIN);
        if (v > lim_hi) begin
            hb_sat = SAT_MAX;
        end else if (v < lim_lo) begin
            hb_sat = SAT_MIN;
        end else begin
            hb_sat = v[HB_DW-1:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/hb_interp2_mac.sv
`default_nettype none
// ============================================================================
// Module   : hb_interp2_mac
// Brief    : Combinational pre-add, coefficient multiply and accumulate.
// Revision : 1.0 - initial release
// ============================================================================
module hb_interp2_mac
    import hb_pkg::*;
#(
    parameter int DW = HB_DW,
    parameter int CW = HB_CW,
    parameter int AW = HB_AW
) (
    input  logic signed [DW-1:0] i_a,
    input  logic signed [DW-1:0] i_b,
    input  logic signed [CW-1:0] i_coef,
    input  logic signed [AW-1:0] i_acc,
    output logic signed [AW-1:0] o_acc
);

    logic signed [DW:0]    w_preadd;
    logic signed [DW+CW:0] w_prod;

    assign w_preadd = $signed({i_a[DW-1], i_a}) + $signed({i_b[DW-1], i_b});
    assign w_prod   = (DW+CW+1)'(w_preadd) * (DW+CW+1)'(i_coef);
    assign o_acc    = i_acc + AW'(w_prod);

endmodule
`default_nettype wire

// File: rtl/hb_interp2.sv
`default_nettype none
// ============================================================================
// Module   : hb_interp2
// Brief    : Halfband interpolate-by-2; one time-shared MAC for the even phase,
//            odd phase is the centre delay tap.
// Revision : 1.0 - initial release
// ============================================================================
module hb_interp2
    import hb_pkg::*;
#(
    parameter int DW = HB_DW,
    parameter int CW = HB_CW,
    parameter int AW = HB_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_phase
);

    hb_state_t             r_state;
    hb_state_t             w_state_nxt;
    logic [5:0][DW-1:0]    r_dly;
    logic signed [AW-1:0]  r_acc;
    logic [DW-1:0]         r_out_data;
    logic                  r_out_phase;
    logic                  r_alive;

    logic signed [DW-1:0]  w_mac_a;
    logic signed [DW-1:0]  w_mac_b;
    logic signed [CW-1:0]  w_mac_coef;
    logic signed [AW-1:0]  w_acc_nxt;
    logic signed [AW-1:0]  w_rnd_sum;
    logic signed [AW-1:0]  w_shifted;
    logic signed [DW-1:0]  w_even;
    logic                  w_in_fire;

    // r_alive keeps in_ready low until the first clock after reset release
    assign in_ready  = r_alive && (r_state == ST_IDLE);
    assign w_in_fire = in_ready && in_valid;
    assign out_valid = (r_state == ST_OUT_E) || (r_state == ST_OUT_O);
    assign out_data  = r_out_data;
    assign out_phase = r_out_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_in_fire) w_state_nxt = ST_MAC0;
            ST_MAC0:  w_state_nxt = ST_MAC1;
            ST_MAC1:  w_state_nxt = ST_MAC2;
            ST_MAC2:  w_state_nxt = ST_RND;
            ST_RND:   w_state_nxt = ST_OUT_E;
            ST_OUT_E: if (out_ready) w_state_nxt = ST_OUT_O;
            ST_OUT_O: if (out_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_mac_a    = '0;
        w_mac_b    = '0;
        w_mac_coef = '0;
        case (r_state)
            ST_MAC0: begin
                w_mac_a    = $signed(r_dly[0]);
                w_mac_b    = $signed(r_dly[5]);
                w_mac_coef = CW'(HB_C0);
            end
            ST_MAC1: begin
                w_mac_a    = $signed(r_dly[1]);
                w_mac_b    = $signed(r_dly[4]);
                w_mac_coef = CW'(HB_C2);
            end
            ST_MAC2: begin
                w_mac_a    = $signed(r_dly[2]);
                w_mac_b    = $signed(r_dly[3]);
                w_mac_coef = CW'(HB_C4);
            end
            default: ;
        endcase
    end

    hb_interp2_mac #(
        .DW (DW),
        .CW (CW),
        .AW (AW)
    ) u_mac (
        .i_a    (w_mac_a),
        .i_b    (w_mac_b),
        .i_coef (w_mac_coef),
        .i_acc  (r_acc),
        .o_acc  (w_acc_nxt)
    );

    // Shift of 16 rather than 17 applies the interpolation gain of 2
    assign w_rnd_sum = r_acc + AW'(RND_HALF);
    assign w_shifted = w_rnd_sum >>> RND_SHIFT;
    assign w_even    = hb_sat(w_shifted);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly       <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_phase <= 1'b0;
            r_alive     <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_in_fire) begin
                        r_dly <= {r_dly[4:0], in_data};
                        r_acc <= '0;
                    end
                end
                ST_MAC0, ST_MAC1, ST_MAC2: r_acc <= w_acc_nxt;
                ST_RND: begin
                    r_out_data  <= w_even;
                    r_out_phase <= 1'b0;
                end
                ST_OUT_E: begin
                    if (out_ready) begin
                        r_out_data  <= r_dly[2];
                        r_out_phase <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hb_interp2.sv
`default_nettype none
// ============================================================================
// Module   : tb_hb_interp2
// Brief    : Directed, table-driven checks for the halfband interpolator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hb_interp2;

    localparam int DW = 18;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_phase;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit rst_before;
        int din;
        bit chk_even;
        int even;
        int odd;
    } vec_t;

    vec_t tbl[$];

    hb_interp2 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_phase (out_phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    task automatic add(input bit r, input int d, input bit ce, input int e, input int o);
        vec_t v;
        v.rst_before = r;
        v.din        = d;
        v.chk_even   = ce;
        v.even       = e;
        v.odd        = o;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", $signed(out_data), 0);
        check("rst_out_phase", out_phase, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
    endtask

    task automatic send_sample(input int din);
        int t;
        t = 0;
        @(negedge clk);
        in_data  = din[DW-1:0];
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) timeout("in_ready_wait");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        int t;
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        ok = out_valid;
        if (!ok) timeout("out_valid_wait");
    endtask

    task automatic run_row(input int i, input bit allow_rst);
        vec_t v;
        bit   ok;
        v = tbl[i];
        if (v.rst_before && allow_rst) do_reset();
        send_sample(v.din);
        wait_out(ok);
        if (ok) begin
            check($sformatf("row%0d_phase_even", i), out_phase, 0);
            if (v.chk_even) check($sformatf("row%0d_even", i), $signed(out_data), v.even);
            @(negedge clk);
            check($sformatf("row%0d_valid_odd", i), out_valid, 1);
            check($sformatf("row%0d_phase_odd", i), out_phase, 1);
            check($sformatf("row%0d_odd", i), $signed(out_data), v.odd);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cnt;
        logic [31:0] got_d [2];
        logic        got_p [2];

        // impulse: rows 0..6
        add(1, 65536, 1,  1043,     0);
        add(0,     0, 1, -7125,     0);
        add(0,     0, 1, 38855, 65536);
        add(0,     0, 1, 38855,     0);
        add(0,     0, 1, -7125,     0);
        add(0,     0, 1,  1043,     0);
        add(0,     0, 1,     0,     0);
        // DC 65536: rows 7..16
        add(1, 65536, 1,  1043,     0);
        add(0, 65536, 1, -6082,     0);
        add(0, 65536, 1, 32773, 65536);
        add(0, 65536, 1, 71628, 65536);
        add(0, 65536, 1, 64503, 65536);
        for (int k = 0; k < 5; k++) add(0, 65536, 1, 65546, 65536);
        // DC 131071, even checked only once the history is full: rows 17..26
        add(1, 131071, 0, 0, 0);
        add(0, 131071, 0, 0, 0);
        for (int k = 0; k < 3; k++) add(0, 131071, 0, 0, 131071);
        for (int k = 0; k < 5; k++) add(0, 131071, 1, 131071, 131071);
        // DC -131072: rows 27..36
        add(1, -131072, 1,   -2086,       0);
        add(0, -131072, 1,   12164,       0);
        add(0, -131072, 1,  -65546, -131072);
        add(0, -131072, 1, -131072, -131072);
        add(0, -131072, 1, -129006, -131072);
        for (int k = 0; k < 5; k++) add(0, -131072, 1, -131072, -131072);
        // follow-up to the backpressure impulse: row 37
        add(0, 0, 1, -7125, 0);

        do_reset();

        // latency / handshake
        do_reset();
        @(negedge clk);
        in_data  = 18'd12345;
        in_valid = 1'b1;
        check("lat_in_ready_c0", in_ready, 1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("lat_out_valid_c%0d", k), out_valid, (k == 5 || k == 6));
            check($sformatf("lat_in_ready_c%0d", k), in_ready, (k >= 7));
            if (k == 5) check("lat_phase_c5", out_phase, 0);
            if (k == 6) check("lat_phase_c6", out_phase, 1);
        end

        for (int i = 0; i <= 36; i++) run_row(i, 1'b1);

        // backpressure: hold in OUT_E, pulse in_valid, then release
        begin
            bit ok;
            do_reset();
            out_ready = 1'b0;
            send_sample(65536);
            wait_out(ok);
            check("bp_first_even", $signed(out_data), 1043);
            for (int i = 0; i < 20; i++) begin
                in_data  = 18'd777;
                in_valid = (i % 2 == 0);
                @(negedge clk);
                check("bp_hold_valid", out_valid, 1);
                check("bp_hold_phase", out_phase, 0);
                check("bp_hold_data", $signed(out_data), 1043);
                check("bp_in_ready", in_ready, 0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            cnt = 0;
            for (int i = 0; i < 12; i++) begin
                if (out_valid && out_ready) begin
                    if (cnt < 2) begin
                        got_d[cnt] = 32'($signed(out_data));
                        got_p[cnt] = out_phase;
                    end
                    cnt++;
                end
                @(negedge clk);
            end
            check("bp_release_count", cnt, 2);
            check("bp_rel_even_data", got_d[0], 1043);
            check("bp_rel_even_phase", got_p[0], 0);
            check("bp_rel_odd_data", got_d[1], 0);
            check("bp_rel_odd_phase", got_p[1], 1);
            run_row(37, 1'b0);
        end

        // asynchronous reset during MAC1, then impulse from a clean history
        for (int i = 7; i <= 9; i++) run_row(i, 1'b1);
        send_sample(65536);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", $signed(out_data), 0);
        check("mid_rst_out_phase", out_phase, 0);
        check("mid_rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready_after", in_ready, 1);
        for (int i = 0; i <= 6; i++) run_row(i, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hb_interp2.md
Name: hb_interp2

Overview:
- Halfband interpolate-by-2 filter for the playback/test-stimulus path. It is the inverse-direction counterpart of the first halfband decimator stage.
- Takes Q1.17 samples at rate Fs and produces 2 Q1.17 samples per input at 2Fs.
- Uses the same 11-tap halfband prototype as the decimator, split polyphase. A single time-multiplexed pre-add/multiply/accumulate unit computes the even phase. The odd phase is a pure delay tap.

Parameters:
- DW, 18, sample width (signed Q1.17) for input and output.
- CW, 25, coefficient width (signed Q8.17).
- AW, 48, accumulator width.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  DW  input sample, signed Q1.17.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a sample; high only in IDLE.
- out_data  out  DW  output sample, signed Q1.17.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_phase  out  1  0 = even output, 1 = odd output; meaningful only while out_valid is high.

Behaviour:
- Coefficients (Q8.17, constant):
  - C0 = 0x0000413 (1043)
  - C2 = -7125 (0x1FFE42B)
  - C4 = 0x00097C7 (38855)
  - Centre tap 0.5, folded into the odd phase as gain 1.
- Delay line s[0..5], DW bits each; s[0] is the newest sample. On an input handshake: s[k] <= s[k-1] and s[0] <= in_data.
- Even output: acc = C0*(s0+s5) + C2*(s1+s4) + C4*(s2+s3).
  - Pre-add is DW+1 bits.
  - Product is sign-extended to AW.
  - even = sat_DW((acc + 2^15) >>> 16). The interpolation gain of 2 is folded into the shift.
- Odd output = s2, passed through unchanged.
- sat_DW clamps to [-131072, 131071].
- FSM states: IDLE, MAC0, MAC1, MAC2, RND, OUT_E, OUT_O.
  - IDLE: in_ready=1. On in_valid: shift delay line, clear acc, go to MAC0.
  - MAC0: acc += C0*(s0+s5).
  - MAC1: acc += C2*(s1+s4).
  - MAC2: acc += C4*(s2+s3).
  - RND: register the rounded, saturated even value into out_data; out_phase=0. Go to OUT_E.
  - OUT_E: out_valid=1. On out_ready: load out_data=s2, out_phase=1, go to OUT_O.
  - OUT_O: out_valid=1. On out_ready: go to IDLE; out_valid falls the next cycle.
- Latency: input handshake on cycle 0 gives out_valid (even) on cycle 5. With out_ready held high, the odd output follows on cycle 6.
- Maximum throughput is 1 input per 7 cycles.
- Backpressure: out_data, out_phase and out_valid hold stable while out_valid=1 and out_ready=0. No sample is dropped or duplicated.
- in_ready is deasserted in every state other than IDLE. in_valid asserted outside IDLE has no effect.
- Reset values (rst_n low, asynchronous, also mid-operation):
  - FSM = IDLE, in_ready=0 while in reset then 1.
  - out_valid=0, out_data=0, out_phase=0.
  - acc=0, s[0..5]=0.
  - The first sample after reset sees a zero history.
- Arithmetic: all operands are signed; the shift is arithmetic; there is no accumulator wrap (AW=48 is ample).
- Saturation happens only at the output.

Decomposition:
- Shared package (hb_pkg):
  - widths DW/CW/AW
  - HB coefficient constants, shared with the decimator stages
  - SAT_MAX/SAT_MIN
  - round constant 2^15
  - FSM state encoding
- Sub-module hb_interp2_mac: combinational pre-add (a+b), multiply by coefficient, add to acc_in, AW-wide output. It is the single arithmetic unit, kept separable for later DSP48 mapping.

Test Plan:
- Impulse: drive 65536 then zeros, out_ready=1.
  - Even outputs per input n=0..6: 1043, -7125, 38855, 38855, -7125, 1043, 0.
  - Odd outputs: 0, 0, 65536, 0, 0, 0, 0.
- DC: hold in_data=65536 for 10 inputs. Steady state gives even=65546 and odd=65536, alternating, with out_phase 0/1.
- Saturation:
  - DC 131071 gives steady even=131071 (clamped) and odd=131071.
  - DC -131072 gives even=-131072 and odd=-131072.
- Backpressure:
  - Hold out_ready=0 for 20 cycles in OUT_E. out_data, out_phase and out_valid must stay stable.
  - in_ready=0 throughout; in_valid pulses are ignored.
  - Releasing out_ready yields exactly 2 outputs.
- Latency/handshake: input accepted on cycle 0 gives out_valid on cycle 5 and the odd output on cycle 6. in_ready returns high on cycle 7.
- Reset mid-operation:
  - Assert rst_n=0 during MAC1. out_valid=0 and out_data=0 immediately, asynchronously.
  - After release, an impulse reproduces the first scenario exactly, confirming the delay line was cleared.
